// File: rtl/id_stage.sv
// id_stage: LoongArch32 decode stage with register file, forwarding, load-use interlock and branch resolution
module id_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_to_id_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        id_allowin,
  output logic        br_taken,
  output logic [31:0] br_target,
  input  logic        ex_allowin,
  output logic        id_to_ex_valid,
  output logic [31:0] ex_pc,
  output logic [11:0] alu_op,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic        mem_we,
  output logic        res_from_mem,
  output logic [31:0] st_data,
  input  logic        ex_dest_valid,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_dest,
  input  logic [31:0] ex_result,
  input  logic        mem_dest_valid,
  input  logic [4:0]  mem_dest,
  input  logic [31:0] mem_result,
  input  logic        wb_rf_we,
  input  logic [4:0]  wb_rf_waddr,
  input  logic [31:0] wb_rf_wdata
);
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] rf [32];
  logic [4:0]  rd, rj, rk;
  logic [11:0] si12;
  logic [15:0] si16;
  logic [19:0] si20;
  logic [25:0] offs26;
  logic [16:0] op17;
  logic [9:0]  op10;
  logic [5:0]  op6;
  logic [6:0]  op7;
  logic i_add, i_sub, i_slt, i_sltu, i_nor, i_and, i_or, i_xor;
  logic i_slli, i_srli, i_srai, i_addi, i_ld, i_st;
  logic i_jirl, i_b, i_bl, i_beq, i_bne, i_lu12i;
  logic is_reg, is_shf, is_mimm, use_rj, use_rk, use_rd, link, taken;
  logic load_use, id_ready_go;
  logic [31:0] rj_val, rk_val, rd_val, br_off16, br_off26;

  assign rd     = id_inst[4:0];
  assign rj     = id_inst[9:5];
  assign rk     = id_inst[14:10];
  assign si12   = id_inst[21:10];
  assign si16   = id_inst[25:10];
  assign si20   = id_inst[24:5];
  assign offs26 = {id_inst[9:0], id_inst[25:10]};
  assign op17   = id_inst[31:15];
  assign op10   = id_inst[31:22];
  assign op6    = id_inst[31:26];
  assign op7    = id_inst[31:25];

  assign i_add   = op17 == 17'h20;
  assign i_sub   = op17 == 17'h22;
  assign i_slt   = op17 == 17'h24;
  assign i_sltu  = op17 == 17'h25;
  assign i_nor   = op17 == 17'h28;
  assign i_and   = op17 == 17'h29;
  assign i_or    = op17 == 17'h2a;
  assign i_xor   = op17 == 17'h2b;
  assign i_slli  = op17 == 17'h81;
  assign i_srli  = op17 == 17'h89;
  assign i_srai  = op17 == 17'h91;
  assign i_addi  = op10 == 10'h00a;
  assign i_ld    = op10 == 10'h0a2;
  assign i_st    = op10 == 10'h0a6;
  assign i_jirl  = op6 == 6'h13;
  assign i_b     = op6 == 6'h14;
  assign i_bl    = op6 == 6'h15;
  assign i_beq   = op6 == 6'h16;
  assign i_bne   = op6 == 6'h17;
  assign i_lu12i = op7 == 7'h0a;

  assign is_reg  = i_add | i_sub | i_slt | i_sltu | i_nor | i_and | i_or | i_xor;
  assign is_shf  = i_slli | i_srli | i_srai;
  assign is_mimm = i_addi | i_ld | i_st;
  assign link    = i_bl | i_jirl;
  assign use_rj  = is_reg | is_shf | is_mimm | i_jirl | i_beq | i_bne;
  assign use_rk  = is_reg;
  assign use_rd  = i_st | i_beq | i_bne;

  assign rj_val = rj == 5'd0 ? 32'd0 :
                  (ex_dest_valid & ~ex_is_load & ex_dest == rj) ? ex_result :
                  (mem_dest_valid & mem_dest == rj) ? mem_result :
                  (wb_rf_we & wb_rf_waddr == rj) ? wb_rf_wdata : rf[rj];
  assign rk_val = rk == 5'd0 ? 32'd0 :
                  (ex_dest_valid & ~ex_is_load & ex_dest == rk) ? ex_result :
                  (mem_dest_valid & mem_dest == rk) ? mem_result :
                  (wb_rf_we & wb_rf_waddr == rk) ? wb_rf_wdata : rf[rk];
  assign rd_val = rd == 5'd0 ? 32'd0 :
                  (ex_dest_valid & ~ex_is_load & ex_dest == rd) ? ex_result :
                  (mem_dest_valid & mem_dest == rd) ? mem_result :
                  (wb_rf_we & wb_rf_waddr == rd) ? wb_rf_wdata : rf[rd];

  assign load_use = id_valid & ex_dest_valid & ex_is_load & ex_dest != 5'd0 &
                    ((use_rj & ex_dest == rj) | (use_rk & ex_dest == rk) | (use_rd & ex_dest == rd));
  assign id_ready_go    = ~load_use;
  assign id_allowin     = ~id_valid | (id_ready_go & ex_allowin);
  assign id_to_ex_valid = id_valid & id_ready_go;

  assign taken     = i_b | link | (i_beq & rj_val == rd_val) | (i_bne & rj_val != rd_val);
  assign br_taken  = id_valid & id_ready_go & ex_allowin & taken;
  assign br_off16  = {{14{si16[15]}}, si16, 2'b00};
  assign br_off26  = {{4{offs26[25]}}, offs26, 2'b00};
  assign br_target = (i_b | i_bl) ? id_pc + br_off26 : i_jirl ? rj_val + br_off16 : id_pc + br_off16;

  assign ex_pc        = id_pc;
  assign alu_op       = {i_lu12i, i_srai, i_srli, i_slli, i_xor, i_or, i_nor, i_and, i_sltu, i_slt, i_sub,
                         i_add | is_mimm | link};
  assign alu_src1     = link ? id_pc : rj_val;
  assign alu_src2     = is_reg  ? rk_val :
                        is_shf  ? {27'd0, rk} :
                        is_mimm ? {{20{si12[11]}}, si12} :
                        i_lu12i ? {si20, 12'd0} :
                        link    ? 32'd4 : 32'd0;
  assign rf_we        = is_reg | is_shf | i_addi | i_ld | i_lu12i | link;
  assign rf_waddr     = i_bl ? 5'd1 : rd;
  assign mem_we       = i_st;
  assign res_from_mem = i_ld;
  assign st_data      = rd_val;

  // pipeline register: load when ID can accept, dropping the wrong-path fetch on a taken branch
  always_ff @(posedge clk) begin
    if (!resetn) id_valid <= 1'b0;
    else if (id_allowin) begin
      id_valid <= if_to_id_valid & ~br_taken;
      id_pc    <= if_pc;
      id_inst  <= if_inst;
    end
  end

  // register file write port; r0 stays hardwired to zero
  always_ff @(posedge clk) begin
    if (wb_rf_we && wb_rf_waddr != 5'd0) rf[wb_rf_waddr] <= wb_rf_wdata;
  end
endmodule
